calc_operand_sequencer: RTL and testbench

//  Front-end controller for the 4-bit signed combinational calculator.
//  - Collects A, B and OP from shared switches over successive "enter" presses.
//  - Drives them to the calculator; registers its R/ovf result.
//  - Holds the result for display and can chain it back in as the next A.

---
 rtl/calc_operand_sequencer.sv | 135 +++++++++++++
 tb/tb_calc_operand_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_operand_sequencer.sv
// Front-end sequencer for a 4-bit signed calculator. It collects A, B and OP from shared
// switches on successive enter presses, issues them, and latches the R/ovf result.
module calc_operand_sequencer #(
    parameter int W   = 4,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   sw,
    input  logic           enter,
    input  logic           clear,
    input  logic           chain,
    output logic [OPW-1:0] calc_op,
    output logic [W-1:0]   calc_a,
    output logic [W-1:0]   calc_b,
    input  logic [W-1:0]   calc_r,
    input  logic           calc_ovf,
    output logic [W-1:0]   result,
    output logic           result_ovf,
    output logic           result_valid,
    output logic           done,
    output logic [2:0]     state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_GET_OP = 3'd3,
        S_ISSUE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_enter_q;
    logic           w_press;
    logic [OPW-1:0] r_calc_op;
    logic [W-1:0]   r_calc_a;
    logic [W-1:0]   r_calc_b;
    logic [W-1:0]   r_result;
    logic           r_result_ovf;
    logic           r_result_valid;
    logic           r_done;

    // A held button yields a single press: only the 0->1 transition counts.
    assign w_press = enter & ~r_enter_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_press) w_next = S_GET_A;
                S_GET_A:  if (w_press) w_next = S_GET_B;
                S_GET_B:  if (w_press) w_next = S_GET_OP;
                S_GET_OP: if (w_press) w_next = S_ISSUE;
                S_ISSUE:  w_next = S_DONE;
                S_DONE:   if (w_press) w_next = chain ? S_GET_B : S_GET_A;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enter_q      <= 1'b0;
            r_calc_op      <= '0;
            r_calc_a       <= '0;
            r_calc_b       <= '0;
            r_result       <= '0;
            r_result_ovf   <= 1'b0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_enter_q <= enter;
            r_done    <= 1'b0;
            // Clear aborts the sequence but keeps operands and the last result intact.
            if (clear) begin
                r_result_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_press) r_result_valid <= 1'b0;
                    end
                    S_GET_A: begin
                        if (w_press) r_calc_a <= sw;
                    end
                    S_GET_B: begin
                        if (w_press) r_calc_b <= sw;
                    end
                    S_GET_OP: begin
                        if (w_press) r_calc_op <= sw[OPW-1:0];
                    end
                    S_ISSUE: begin
                        r_result       <= calc_r;
                        r_result_ovf   <= calc_ovf;
                        r_result_valid <= 1'b1;
                        r_done         <= 1'b1;
                    end
                    S_DONE: begin
                        if (w_press) begin
                            if (chain) r_calc_a       <= r_result;
                            else       r_result_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign calc_op      = r_calc_op;
    assign calc_a       = r_calc_a;
    assign calc_b       = r_calc_b;
    assign result       = r_result;
    assign result_ovf   = r_result_ovf;
    assign result_valid = r_result_valid;
    assign done         = r_done;
    assign state_o      = r_state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench for calc_operand_sequencer: a behavioural calculator drives calc_r,
// with directed vectors, multi-cycle corner sequences and randomized chained operations.
module tb_calc_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       enter;
    logic       clear;
    logic       chain;
    logic [2:0] calc_op;
    logic [3:0] calc_a;
    logic [3:0] calc_b;
    logic [3:0] calc_r;
    logic       calc_ovf;
    logic [3:0] result;
    logic       result_ovf;
    logic       result_valid;
    logic       done;
    logic [2:0] state_o;

    int n_total = 0;
    int n_pass  = 0;

    calc_operand_sequencer #(.W(4), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .enter(enter), .clear(clear), .chain(chain),
        .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
        .calc_r(calc_r), .calc_ovf(calc_ovf),
        .result(result), .result_ovf(result_ovf), .result_valid(result_valid),
        .done(done), .state_o(state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural calculator: returns {ovf, r} using plain signed integer arithmetic.
    function automatic logic [4:0] calc_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        int sa;
        int sb;
        int s;
        logic [3:0] r;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = 1'b0;
        case (op)
            3'd0: begin s = sa + sb; r = s[3:0]; ovf = (s > 7) || (s < -8); end
            3'd1: begin s = sa - sb; r = s[3:0]; ovf = (s > 7) || (s < -8); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = {a[2:0], 1'b0};
            default: r = b;
        endcase
        return {ovf, r};
    endfunction

    always_comb {calc_ovf, calc_r} = calc_fn(calc_a, calc_b, calc_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        sw    = v;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    // From IDLE or DONE (chain low): start, A, B, OP. Ends just after the capture edge.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        chain = 1'b0;
        press(4'h0);
        press(a);
        press(b);
        press({1'b0, op});
    endtask

    task automatic check_capture(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                                 input logic [2:0] eop, input logic [4:0] exp);
        check({tag, " done"},   done, 1);
        check({tag, " state"},  state_o, 5);
        check({tag, " calc_a"}, calc_a, ea);
        check({tag, " calc_b"}, calc_b, eb);
        check({tag, " op"},     calc_op, eop);
        check({tag, " result"}, result, exp[3:0]);
        check({tag, " ovf"},    result_ovf, exp[4]);
        check({tag, " valid"},  result_valid, 1);
        tick();
        check({tag, " done_low"},   done, 0);
        check({tag, " state_hold"}, state_o, 5);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] r;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];
    logic [3:0] prev_r;
    logic [3:0] saved_b;

    initial begin
        vecs[0] = '{4'h3, 4'h2, 3'd0, 4'h5, 1'b0};
        vecs[1] = '{4'h8, 4'h1, 3'd1, 4'h7, 1'b1};
        vecs[2] = '{4'h7, 4'h1, 3'd0, 4'h8, 1'b1};
        vecs[3] = '{4'hF, 4'hF, 3'd0, 4'hE, 1'b0};
        vecs[4] = '{4'h8, 4'h8, 3'd0, 4'h0, 1'b1};
        vecs[5] = '{4'h9, 4'h5, 3'd2, 4'h1, 1'b0};
        vecs[6] = '{4'hA, 4'h5, 3'd3, 4'hF, 1'b0};
        vecs[7] = '{4'h6, 4'h3, 3'd4, 4'h5, 1'b0};
        vecs[8] = '{4'h3, 4'hC, 3'd7, 4'hC, 1'b0};
        vecs[9] = '{4'h0, 4'h1, 3'd1, 4'hF, 1'b0};

        rst_n = 1'b0;
        sw    = '0;
        enter = 1'b0;
        clear = 1'b0;
        chain = 1'b0;
        #12;
        check("rst state",  state_o, 0);
        check("rst calc_a", calc_a, 0);
        check("rst result", result, 0);
        check("rst valid",  result_valid, 0);
        check("rst done",   done, 0);
        rst_n = 1'b1;
        tick();
        check("idle hold", state_o, 0);

        // A+B basic flow, then chain the result in as A.
        run_op(4'h3, 4'h2, 3'd0);
        check_capture("t1", 4'h3, 4'h2, 3'd0, {1'b0, 4'h5});
        chain = 1'b1;
        press(4'hA);
        chain = 1'b0;
        check("chain state", state_o, 2);
        check("chain calc_a", calc_a, 5);
        check("chain valid kept", result_valid, 1);
        press(4'h4);
        press(4'h0);
        check_capture("t3", 4'h5, 4'h4, 3'd0, {1'b1, 4'h9});

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op);
            check_capture($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                          {vecs[i].ovf, vecs[i].r});
        end

        // Held enter in GET_A captures exactly once.
        press(4'h0);
        check("nochain valid", result_valid, 0);
        check("to get_a", state_o, 1);
        sw    = 4'h6;
        enter = 1'b1;
        repeat (20) tick();
        enter = 1'b0;
        tick();
        check("held state", state_o, 2);
        check("held calc_a", calc_a, 6);
        press(4'h2);
        press(4'h1);
        check_capture("held", 4'h6, 4'h2, 3'd1, {1'b0, 4'h4});

        // Clear together with enter in GET_B wins; no phantom press afterwards.
        chain = 1'b1;
        press(4'h0);
        chain = 1'b0;
        check("pre-clear state", state_o, 2);
        saved_b = calc_b;
        sw    = 4'hB;
        clear = 1'b1;
        enter = 1'b1;
        tick();
        clear = 1'b0;
        check("clear state", state_o, 0);
        check("clear calc_b", calc_b, saved_b);
        check("clear valid", result_valid, 0);
        check("clear result kept", result, 4'h4);
        tick();
        check("no phantom", state_o, 0);
        enter = 1'b0;
        tick();

        // Asynchronous reset mid-cycle in GET_OP.
        press(4'h0);
        press(4'h2);
        press(4'h3);
        check("pre-rst state", state_o, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async state",  state_o, 0);
        check("async calc_a", calc_a, 0);
        check("async calc_b", calc_b, 0);
        check("async result", result, 0);
        rst_n = 1'b1;
        tick();
        press(4'h0);
        check("post-rst press", state_o, 1);
        press(4'h1);
        press(4'h1);
        press(4'h0);
        check_capture("post-rst", 4'h1, 4'h1, 3'd0, {1'b0, 4'h2});
        prev_r = 4'h2;

        // Randomized operations with random chaining and inter-press gaps.
        for (int k = 0; k < 40; k++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic [2:0] op;
            logic       ch;
            logic [3:0] ea;
            logic [4:0] exp;
            a  = 4'($urandom);
            b  = 4'($urandom);
            op = 3'($urandom);
            ch = 1'($urandom_range(0, 1));
            ea = ch ? prev_r : a;
            chain = ch;
            press(4'($urandom));
            chain = 1'b0;
            check("rnd valid after restart", result_valid, 32'(ch));
            repeat ($urandom_range(0, 2)) tick();
            if (!ch) press(a);
            repeat ($urandom_range(0, 2)) tick();
            press(b);
            repeat ($urandom_range(0, 2)) tick();
            press({1'b0, op});
            exp = calc_fn(ea, b, op);
            check_capture($sformatf("rnd%0d", k), ea, b, op, exp);
            prev_r = exp[3:0];
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
